control_sequencer: RTL and testbench

- Hardwired Moore control unit that sits directly upstream of the datapath and drives its control inputs.
- Steps each instruction through fetch states T0–T2, then through opcode-specific execute states T3–T7.
- Takes the IR opcode back from the datapath.
- Supports load/store, ALU register/immediate ops, mul/div, mfhi/mflo, in/out, nop and halt.

---
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 tb/tb_control_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the datapath.
// Walks every instruction through fetch (T0-T2) and opcode-specific
// execute states (T3-T7), then back to T0. halt parks in HALT until Clear.
//
// Ports:
//   Clock            system clock, rising edge
//   Clear            synchronous active-high reset, overrides everything
//   opcode[4:0]      IR[31:27] from the datapath, decoded only in T3-T7
//   PCout..OutPortIn datapath control strobes, decoded from state + opcode
//   Run              high in T0-T7, low in IDLE and HALT
module control_sequencer (
   input  logic       Clock,
   input  logic       Clear,
   input  logic [4:0] opcode,
   output logic       PCout,
   output logic       PCin,
   output logic       IncPC,
   output logic       MARin,
   output logic       MDRin,
   output logic       MDRout,
   output logic       Read,
   output logic       IRin,
   output logic       Yin,
   output logic       ZLowIn,
   output logic       ZHighIn,
   output logic       ZLowout,
   output logic       ZHighout,
   output logic       HIin,
   output logic       LOin,
   output logic       HIout,
   output logic       LOout,
   output logic       Cout,
   output logic       BAout,
   output logic       GRA,
   output logic       GRB,
   output logic       GRC,
   output logic       Rin,
   output logic       Rout,
   output logic       RAMin,
   output logic       InPortOut,
   output logic       OutPortIn,
   output logic       Run
);

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   // Opcodes from here up all finish in T3 (in/out/mfhi/mflo/nop/halt/unlisted).
   localparam logic [4:0] OP_SHORT = 5'b10000;
   localparam logic [4:0] OP_IN   = 5'b10101;
   localparam logic [4:0] OP_OUT  = 5'b10110;
   localparam logic [4:0] OP_MFHI = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11010;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_t;

   state_t state, state_nxt;

   // State register
   always_ff @(posedge Clock) begin
      if (Clear) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next state: instruction length depends on the opcode held from T3 on
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: state_nxt = S_T0;
         S_T0:   state_nxt = S_T1;
         S_T1:   state_nxt = S_T2;
         S_T2:   state_nxt = S_T3;
         S_T3: begin
            if (opcode == OP_HALT)       state_nxt = S_HALT;
            else if (opcode >= OP_SHORT) state_nxt = S_T0;
            else                         state_nxt = S_T4;
         end
         S_T4:   state_nxt = S_T5;
         S_T5: begin
            if (opcode == OP_LD || opcode == OP_ST ||
                opcode == OP_MUL || opcode == OP_DIV) state_nxt = S_T6;
            else                                      state_nxt = S_T0;
         end
         S_T6: begin
            if (opcode == OP_MUL || opcode == OP_DIV) state_nxt = S_T0;
            else                                      state_nxt = S_T7;
         end
         S_T7:   state_nxt = S_T0;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore output decode
   always_comb begin
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      MDRout = 1'b0; Read = 1'b0; IRin = 1'b0; Yin = 1'b0; ZLowIn = 1'b0;
      ZHighIn = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; HIin = 1'b0;
      LOin = 1'b0; HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; BAout = 1'b0;
      GRA = 1'b0; GRB = 1'b0; GRC = 1'b0; Rin = 1'b0; Rout = 1'b0;
      RAMin = 1'b0; InPortOut = 1'b0; OutPortIn = 1'b0;
      Run = (state != S_IDLE) && (state != S_HALT);
      case (state)
         S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
         S_T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
         S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
         S_T3: begin
            case (opcode) inside
               OP_LD, OP_LDI, OP_ST: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               [OP_ADD:OP_OR], [OP_ADDI:OP_ORI]: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               OP_MUL, OP_DIV: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               OP_IN:   begin InPortOut = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               OP_OUT:  begin GRA = 1'b1; Rout = 1'b1; OutPortIn = 1'b1; end
               OP_MFHI: begin GRA = 1'b1; Rin = 1'b1; HIout = 1'b1; end
               OP_MFLO: begin GRA = 1'b1; Rin = 1'b1; LOout = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            case (opcode) inside
               OP_LD, OP_LDI, OP_ST, [OP_ADDI:OP_ORI]: begin Cout = 1'b1; ZLowIn = 1'b1; end
               [OP_ADD:OP_OR]: begin GRC = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; end
               OP_MUL, OP_DIV: begin
                  GRB = 1'b1; Rout = 1'b1; ZLowIn = 1'b1; ZHighIn = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (opcode) inside
               OP_LD, OP_ST: begin ZLowout = 1'b1; MARin = 1'b1; end
               OP_LDI, [OP_ADD:OP_ORI]: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               OP_MUL, OP_DIV: begin ZLowout = 1'b1; LOin = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            case (opcode) inside
               OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
               OP_ST: begin GRA = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               OP_MUL, OP_DIV: begin ZHighout = 1'b1; HIin = 1'b1; end
               default: ;
            endcase
         end
         S_T7: begin
            case (opcode) inside
               OP_LD: begin MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
               OP_ST: RAMin = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: constant vector table, directed multi-cycle
// sequences and randomized opcodes checked against a microcode-table model.
module tb_control_sequencer;

   logic       Clock = 1'b0;
   logic       Clear;
   logic [4:0] opcode;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, ZLowIn;
   logic ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout, Cout, BAout;
   logic GRA, GRB, GRC, Rin, Rout, RAMin, InPortOut, OutPortIn, Run;

   control_sequencer dut (
      .Clock(Clock), .Clear(Clear), .opcode(opcode),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
      .ZHighIn(ZHighIn), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin),
      .LOin(LOin), .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout),
      .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .RAMin(RAMin),
      .InPortOut(InPortOut), .OutPortIn(OutPortIn), .Run(Run)
   );

   always #5 Clock = ~Clock;

   logic [26:0] ctl;
   assign ctl = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin,
                 ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, LOin, HIout, LOout,
                 Cout, BAout, GRA, GRB, GRC, Rin, Rout, RAMin, InPortOut, OutPortIn};

   localparam logic [26:0] C_PCOUT = 27'(1) << 26, C_PCIN = 27'(1) << 25;
   localparam logic [26:0] C_INCPC = 27'(1) << 24, C_MARIN = 27'(1) << 23;
   localparam logic [26:0] C_MDRIN = 27'(1) << 22, C_MDROUT = 27'(1) << 21;
   localparam logic [26:0] C_READ = 27'(1) << 20, C_IRIN = 27'(1) << 19;
   localparam logic [26:0] C_YIN = 27'(1) << 18, C_ZLOWIN = 27'(1) << 17;
   localparam logic [26:0] C_ZHIGHIN = 27'(1) << 16, C_ZLOWOUT = 27'(1) << 15;
   localparam logic [26:0] C_ZHIGHOUT = 27'(1) << 14, C_HIIN = 27'(1) << 13;
   localparam logic [26:0] C_LOIN = 27'(1) << 12, C_HIOUT = 27'(1) << 11;
   localparam logic [26:0] C_LOOUT = 27'(1) << 10, C_COUT = 27'(1) << 9;
   localparam logic [26:0] C_BAOUT = 27'(1) << 8, C_GRA = 27'(1) << 7;
   localparam logic [26:0] C_GRB = 27'(1) << 6, C_GRC = 27'(1) << 5;
   localparam logic [26:0] C_RIN = 27'(1) << 4, C_ROUT = 27'(1) << 3;
   localparam logic [26:0] C_RAMIN = 27'(1) << 2, C_INPORTOUT = 27'(1) << 1;
   localparam logic [26:0] C_OUTPORTIN = 27'(1);

   localparam logic [26:0] F0 = C_PCOUT | C_MARIN | C_INCPC | C_ZLOWIN;
   localparam logic [26:0] F1 = C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN;
   localparam logic [26:0] F2 = C_MDROUT | C_IRIN;

   // Instruction classes of the reference model
   localparam int K_LD = 0, K_LDI = 1, K_ST = 2, K_RT = 3, K_IMM = 4, K_MD = 5;
   localparam int K_IN = 6, K_OUT = 7, K_MFHI = 8, K_MFLO = 9, K_NOP = 10, K_HALT = 11;

   logic [26:0] seq [12][5];
   int          exec_len [12];

   // Model state: mode 0 idle, 1 running step m_k (0..7), 2 halted
   int m_mode = 0;
   int m_k    = 0;

   int vectors     = 0;
   int miscompares = 0;
   bit ramin_seen  = 1'b0;

   typedef struct {
      logic        clr;
      logic [4:0]  op;
      logic [26:0] ctl;
      logic        run;
   } vec_t;
   vec_t tv [11];

   function automatic int cls_of(input logic [4:0] op);
      int v = int'(op);
      if (v == 0)              return K_LD;
      if (v == 1)              return K_LDI;
      if (v == 2)              return K_ST;
      if (v >= 3 && v <= 10)   return K_RT;
      if (v >= 11 && v <= 13)  return K_IMM;
      if (v == 14 || v == 15)  return K_MD;
      if (v == 21)             return K_IN;
      if (v == 22)             return K_OUT;
      if (v == 23)             return K_MFHI;
      if (v == 24)             return K_MFLO;
      if (v == 26)             return K_HALT;
      return K_NOP;
   endfunction

   function automatic logic [27:0] model_out(input logic [4:0] op);
      if (m_mode != 1) return 28'd0;
      if (m_k == 0) return {1'b1, F0};
      if (m_k == 1) return {1'b1, F1};
      if (m_k == 2) return {1'b1, F2};
      return {1'b1, seq[cls_of(op)][m_k-3]};
   endfunction

   task automatic model_step(input logic clr, input logic [4:0] op);
      if (clr) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         m_mode = 1; m_k = 0;
      end else if (m_mode == 1) begin
         if (m_k >= 3 && (m_k - 3) == exec_len[cls_of(op)] - 1) begin
            if (cls_of(op) == K_HALT) m_mode = 2;
            else                      m_k = 0;
         end else begin
            m_k = m_k + 1;
         end
      end
   endtask

   task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t: run/ctl got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One clock: drive, check at negedge, advance the model at the edge
   task automatic apply(input logic clr, input logic [4:0] op, input bit use_exp,
                        input logic [26:0] e_ctl, input logic e_run, input string name);
      logic [27:0] exp;
      Clear = clr; opcode = op;
      @(negedge Clock);
      exp = use_exp ? {e_run, e_ctl} : model_out(op);
      check(name, {Run, ctl}, exp);
      vectors++;
      if ((Rin && Rout) || (Read && RAMin)) begin
         miscompares++;
         $display("FAIL exclusive_strobes t=%0t: Rin=%b Rout=%b Read=%b RAMin=%b, required no overlap",
                  $time, Rin, Rout, Read, RAMin);
      end
      if (RAMin) ramin_seen = 1'b1;
      @(posedge Clock);
      model_step(clr, op);
      #1;
   endtask

   // Run from T0 to the next T0 (or HALT); fetch states see junk opcodes
   task automatic instr(input logic [4:0] op, input int exp_len, input string name);
      int n = 0;
      do begin
         apply(1'b0, (m_mode == 1 && m_k >= 3) ? op : 5'($urandom_range(31)), 1'b0, '0, 1'b0, name);
         n++;
      end while (m_mode == 1 && m_k != 0 && n < 64);
      if (exp_len > 0) begin
         vectors++;
         if (n != exp_len) begin
            miscompares++;
            $display("FAIL %s_length: got %0d clocks, required %0d", name, n, exp_len);
         end
      end
   endtask

   initial begin
      for (int c = 0; c < 12; c++) for (int s = 0; s < 5; s++) seq[c][s] = '0;
      seq[K_LD]   = '{C_GRB|C_BAOUT|C_YIN, C_COUT|C_ZLOWIN, C_ZLOWOUT|C_MARIN,
                      C_READ|C_MDRIN, C_MDROUT|C_GRA|C_RIN};
      seq[K_LDI]  = '{C_GRB|C_BAOUT|C_YIN, C_COUT|C_ZLOWIN, C_ZLOWOUT|C_GRA|C_RIN, '0, '0};
      seq[K_ST]   = '{C_GRB|C_BAOUT|C_YIN, C_COUT|C_ZLOWIN, C_ZLOWOUT|C_MARIN,
                      C_GRA|C_ROUT|C_MDRIN, C_RAMIN};
      seq[K_RT]   = '{C_GRB|C_ROUT|C_YIN, C_GRC|C_ROUT|C_ZLOWIN, C_ZLOWOUT|C_GRA|C_RIN, '0, '0};
      seq[K_IMM]  = '{C_GRB|C_ROUT|C_YIN, C_COUT|C_ZLOWIN, C_ZLOWOUT|C_GRA|C_RIN, '0, '0};
      seq[K_MD]   = '{C_GRA|C_ROUT|C_YIN, C_GRB|C_ROUT|C_ZLOWIN|C_ZHIGHIN,
                      C_ZLOWOUT|C_LOIN, C_ZHIGHOUT|C_HIIN, '0};
      seq[K_IN][0]   = C_INPORTOUT | C_GRA | C_RIN;
      seq[K_OUT][0]  = C_GRA | C_ROUT | C_OUTPORTIN;
      seq[K_MFHI][0] = C_GRA | C_RIN | C_HIOUT;
      seq[K_MFLO][0] = C_GRA | C_RIN | C_LOOUT;
      exec_len = '{5, 3, 5, 3, 3, 4, 1, 1, 1, 1, 1, 1};

      tv[0]  = '{1'b1, 5'd0,      27'd0, 1'b0};
      tv[1]  = '{1'b0, 5'd0,      27'd0, 1'b0};
      tv[2]  = '{1'b0, 5'b11010,  F0,    1'b1};
      tv[3]  = '{1'b0, 5'b11010,  F1,    1'b1};
      tv[4]  = '{1'b0, 5'b11010,  F2,    1'b1};
      tv[5]  = '{1'b0, 5'b10111,  C_GRA | C_RIN | C_HIOUT, 1'b1};
      tv[6]  = '{1'b0, 5'b10111,  F0,    1'b1};
      tv[7]  = '{1'b0, 5'b00000,  F1,    1'b1};
      tv[8]  = '{1'b0, 5'b01110,  F2,    1'b1};
      tv[9]  = '{1'b0, 5'b11000,  C_GRA | C_RIN | C_LOOUT, 1'b1};
      tv[10] = '{1'b0, 5'b11000,  F0,    1'b1};

      Clear = 1'b1; opcode = 5'd0;
      repeat (2) @(posedge Clock);
      #1;
      m_mode = 0;

      for (int i = 0; i < 11; i++)
         apply(tv[i].clr, tv[i].op, 1'b1, tv[i].ctl, tv[i].run, $sformatf("table[%0d]", i));
      instr(5'b11001, 0, "drain");

      instr(5'b00000, 8, "ld");
      instr(5'b01110, 7, "mul");
      instr(5'b01111, 7, "div");
      instr(5'b11111, 4, "unlisted");
      instr(5'b00010, 8, "st");
      instr(5'b00001, 6, "ldi");
      instr(5'b11010, 4, "halt");
      repeat (20) apply(1'b0, 5'($urandom_range(31)), 1'b1, '0, 1'b0, "halt_hold");
      apply(1'b1, 5'($urandom_range(31)), 1'b1, '0, 1'b0, "halt_clear");
      apply(1'b0, 5'($urandom_range(31)), 1'b1, '0, 1'b0, "idle_after_halt");
      apply(1'b0, 5'($urandom_range(31)), 1'b1, F0, 1'b1, "t0_after_halt");
      instr(5'b11001, 0, "drain2");

      // Clear during T6 of st: abort before the RAM write strobe
      ramin_seen = 1'b0;
      for (int k = 0; k < 7; k++)
         apply(k == 6, (k >= 3) ? 5'b00010 : 5'($urandom_range(31)), 1'b0, '0, 1'b0, "st_abort");
      apply(1'b0, 5'($urandom_range(31)), 1'b1, '0, 1'b0, "st_abort_idle");
      vectors++;
      if (ramin_seen) begin
         miscompares++;
         $display("FAIL st_abort_ramin: RAMin seen=1, required 0");
      end
      apply(1'b0, 5'($urandom_range(31)), 1'b1, F0, 1'b1, "st_abort_t0");

      // Randomized opcodes, occasional Clear, halts released by Clear
      begin
         logic [4:0] cur_op = 5'd0;
         for (int n = 0; n < 3000; n++) begin
            logic clr;
            if (m_mode == 1 && m_k == 3) cur_op = 5'($urandom_range(31));
            clr = (m_mode == 2) ? ($urandom_range(7) == 0) : ($urandom_range(99) == 0);
            apply(clr, (m_mode == 1 && m_k >= 3) ? cur_op : 5'($urandom_range(31)),
                  1'b0, '0, 1'b0, "random");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
